// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types and constants for the pipeline hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  localparam int MDU_LAT_MAX = 15;
  localparam int MDU_CNT_W   = $clog2(MDU_LAT_MAX + 1);

  // The M stage holds the younger result, so it wins over W.
  function automatic fwd_t fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m) return FWD_MEM;
    if (hit_w) return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module : hazard_ctrl_if
// Brief  : Stage-tagged register addresses in, stall/flush/forward controls out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
) ();
  import hazard_pkg::*;

  logic [REG_ADDR_W-1:0] rs1_D, rs2_D, rd_D;
  logic                  reg_wr_D, mdu_op_D;
  logic [REG_ADDR_W-1:0] rs1_E, rs2_E, rd_E;
  wb_sel_t               sel_wb_E;
  logic                  mdu_start_E;
  logic                  br_en_E;
  logic [REG_ADDR_W-1:0] rd_M, rs2_M, rd_W;
  logic                  reg_wr_M, reg_wr_W;

  logic                  stallF, stallD, flushD, flushE;
  fwd_t                  forwardAE, forwardBE;
  logic                  forwardM;
  logic                  mdu_busy, mdu_wb_valid;
  logic [REG_ADDR_W-1:0] mdu_wb_rd;

  modport master (
    output rs1_D, rs2_D, rd_D, reg_wr_D, mdu_op_D,
    output rs1_E, rs2_E, rd_E, sel_wb_E, mdu_start_E, br_en_E,
    output rd_M, rs2_M, rd_W, reg_wr_M, reg_wr_W,
    input  stallF, stallD, flushD, flushE,
    input  forwardAE, forwardBE, forwardM,
    input  mdu_busy, mdu_wb_valid, mdu_wb_rd
  );

  modport slave (
    input  rs1_D, rs2_D, rd_D, reg_wr_D, mdu_op_D,
    input  rs1_E, rs2_E, rd_E, sel_wb_E, mdu_start_E, br_en_E,
    input  rd_M, rs2_M, rd_W, reg_wr_M, reg_wr_W,
    output stallF, stallD, flushD, flushE,
    output forwardAE, forwardBE, forwardM,
    output mdu_busy, mdu_wb_valid, mdu_wb_rd
  );

endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_mdu_scoreboard.sv
// ============================================================================
// Module : mdu_scoreboard
// Brief  : Pending-write bits and latency counter for the fixed-latency MDU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_scoreboard import hazard_pkg::*; #(
  parameter int REG_ADDR_W = 5,
  parameter int MDU_LAT    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [REG_ADDR_W-1:0]      rd_i,
  output logic [2**REG_ADDR_W-1:0]   pend_o,
  output logic                       busy_o,
  output logic                       valid_o,
  output logic [REG_ADDR_W-1:0]      wb_rd_o
);

  localparam int NREG = 2**REG_ADDR_W;

  logic [NREG-1:0]       pend_q, pend_d;
  logic [MDU_CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  busy, last, issue;

  assign busy  = (cnt_q != '0);
  assign last  = (cnt_q == MDU_CNT_W'(1));
  // A start while busy is the structurally stalled op; it is not accepted.
  assign issue = start_i && !busy;

  always_comb begin
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    wb_rd_d = wb_rd_q;
    if (last) pend_d[wb_rd_q] = 1'b0;
    if (busy) cnt_d = cnt_q - MDU_CNT_W'(1);
    if (issue) begin
      cnt_d   = MDU_CNT_W'(MDU_LAT);
      wb_rd_d = rd_i;
      if (rd_i != '0) pend_d[rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      cnt_q   <= '0;
      wb_rd_q <= '0;
    end else begin
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      wb_rd_q <= wb_rd_d;
    end
  end

  assign pend_o  = pend_q;
  assign busy_o  = busy;
  assign valid_o = last;
  assign wb_rd_o = wb_rd_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module : hazard_ctrl
// Brief  : 5-stage pipeline hazard unit with MDU scoreboard; optional
//          performance counters when HAZARD_PERF_CNT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl import hazard_pkg::*; #(
  parameter int REG_ADDR_W = 5,
  parameter int MDU_LAT    = 4,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
  output logic [PERF_W-1:0] mdu_stall_cnt,
`endif
  hazard_ctrl_if.slave      hz
);

  if (MDU_LAT < 2 || MDU_LAT > MDU_LAT_MAX || PERF_W < 1) begin : g_bad_params
    $error("hazard_ctrl: MDU_LAT must be 2..15 and PERF_W positive");
  end

  logic [2**REG_ADDR_W-1:0] pend;
  logic                     mdu_busy;
  logic                     load_use, mdu_issue_haz, mdu_stall, stall, stall_fd;

  mdu_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .MDU_LAT    (MDU_LAT)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .start_i (hz.mdu_start_E),
    .rd_i    (hz.rd_E),
    .pend_o  (pend),
    .busy_o  (mdu_busy),
    .valid_o (hz.mdu_wb_valid),
    .wb_rd_o (hz.mdu_wb_rd)
  );

  assign hz.mdu_busy = mdu_busy;

  assign hz.forwardAE = fwd_sel(hz.reg_wr_M && hz.rd_M == hz.rs1_E && hz.rs1_E != '0,
                                hz.reg_wr_W && hz.rd_W == hz.rs1_E && hz.rs1_E != '0);
  assign hz.forwardBE = fwd_sel(hz.reg_wr_M && hz.rd_M == hz.rs2_E && hz.rs2_E != '0,
                                hz.reg_wr_W && hz.rd_W == hz.rs2_E && hz.rs2_E != '0);
  assign hz.forwardM  = hz.reg_wr_W && hz.rd_W == hz.rs2_M && hz.rs2_M != '0;

  assign load_use = hz.sel_wb_E == WB_MEM && hz.rd_E != '0 &&
                    (hz.rd_E == hz.rs1_D || hz.rd_E == hz.rs2_D);

  // The op in E has not set its pending bit yet, so catch it directly.
  assign mdu_issue_haz = hz.mdu_start_E && hz.rd_E != '0 &&
                         (hz.rd_E == hz.rs1_D || hz.rd_E == hz.rs2_D);

  assign mdu_stall = (pend[hz.rs1_D] && hz.rs1_D != '0) ||
                     (pend[hz.rs2_D] && hz.rs2_D != '0) ||
                     (hz.reg_wr_D && pend[hz.rd_D]) ||
                     (hz.mdu_op_D && mdu_busy);

  assign stall    = load_use || mdu_issue_haz || mdu_stall;
  assign stall_fd = stall && !hz.br_en_E;

  assign hz.stallF = stall_fd;
  assign hz.stallD = stall_fd;
  assign hz.flushE = stall || hz.br_en_E;
  assign hz.flushD = hz.br_en_E;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PERF_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic              mdu_only;

  assign mdu_only = stall_fd && mdu_stall && !load_use && !mdu_issue_haz;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mdu_cnt_d   = mdu_cnt_q;
    if (stall_fd && stall_cnt_q != '1)   stall_cnt_d = stall_cnt_q + PERF_W'(1);
    if (hz.br_en_E && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + PERF_W'(1);
    if (mdu_only && mdu_cnt_q != '1)     mdu_cnt_d   = mdu_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mdu_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mdu_cnt_q   <= mdu_cnt_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign mdu_stall_cnt = mdu_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Self-checking bench for hazard_ctrl (MDU_LAT=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int RAW = 5;
  localparam int LAT = 4;
  localparam int NV  = 14;

  logic clk = 1'b0;
  logic rst;

  hazard_ctrl_if #(.REG_ADDR_W(RAW)) hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, mdu_stall_cnt;
`endif

  hazard_ctrl #(.REG_ADDR_W(RAW), .MDU_LAT(LAT), .PERF_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .mdu_stall_cnt (mdu_stall_cnt),
`endif
    .hz            (hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1D, rs2D, rdD;
    logic       wrD, mopD;
    logic [4:0] rs1E, rs2E, rdE;
    wb_sel_t    sel;
    logic       br;
    logic [4:0] rdM, rs2M, rdW;
    logic       wrM, wrW;
    logic       sF, sD, fD, fE;
    fwd_t       aE, bE;
    logic       fM;
  } vec_t;

  vec_t       vt [NV];
  vec_t       exp_q [$];
  logic [4:0] mdu_q [$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    hz.rs1_D = '0; hz.rs2_D = '0; hz.rd_D = '0; hz.reg_wr_D = 1'b0; hz.mdu_op_D = 1'b0;
    hz.rs1_E = '0; hz.rs2_E = '0; hz.rd_E = '0; hz.sel_wb_E = WB_ALU;
    hz.mdu_start_E = 1'b0; hz.br_en_E = 1'b0;
    hz.rd_M = '0; hz.rs2_M = '0; hz.rd_W = '0; hz.reg_wr_M = 1'b0; hz.reg_wr_W = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic apply(input vec_t v);
    hz.rs1_D = v.rs1D; hz.rs2_D = v.rs2D; hz.rd_D = v.rdD;
    hz.reg_wr_D = v.wrD; hz.mdu_op_D = v.mopD;
    hz.rs1_E = v.rs1E; hz.rs2_E = v.rs2E; hz.rd_E = v.rdE;
    hz.sel_wb_E = v.sel; hz.br_en_E = v.br; hz.mdu_start_E = 1'b0;
    hz.rd_M = v.rdM; hz.rs2_M = v.rs2M; hz.rd_W = v.rdW;
    hz.reg_wr_M = v.wrM; hz.reg_wr_W = v.wrW;
  endtask

  // Samples 1 time unit after inputs settle; pops the MDU scoreboard on writeback.
  task automatic chk_mdu(input string tag, input logic s, input logic b, input logic v);
    #1;
    check({tag, ".stallD"}, hz.stallD, s);
    check({tag, ".busy"}, hz.mdu_busy, b);
    check({tag, ".wb_valid"}, hz.mdu_wb_valid, v);
    if (hz.mdu_wb_valid) begin
      if (mdu_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s.wb_rd: writeback %0d with no MDU op outstanding", tag, hz.mdu_wb_rd);
      end else begin
        check({tag, ".wb_rd"}, hz.mdu_wb_rd, mdu_q.pop_front());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1);
  end

  initial begin
    vec_t e;
    //          rs1D  rs2D  rdD   wrD   mopD  rs1E  rs2E  rdE   sel     br    rdM   rs2M  rdW   wrM   wrW   sF    sD    fD    fE    aE        bE        fM
    vt[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, WB_ALU, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_NONE, 1'b0};
    vt[1]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, WB_ALU, 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FWD_MEM,  FWD_NONE, 1'b0};
    vt[2]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, WB_ALU, 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_NONE, 1'b0};
    vt[3]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd6, 5'd0, WB_ALU, 1'b0, 5'd6, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FWD_WB,   FWD_MEM,  1'b0};
    vt[4]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, WB_ALU, 1'b0, 5'd6, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_WB,   1'b0};
    vt[5]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, WB_ALU, 1'b0, 5'd0, 5'd8, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_NONE, 1'b1};
    vt[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, WB_ALU, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_NONE, 1'b0};
    vt[7]  = '{5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, WB_MEM, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, FWD_NONE, FWD_NONE, 1'b0};
    vt[8]  = '{5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, WB_ALU, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_NONE, 1'b0};
    vt[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, WB_MEM, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_NONE, 1'b0};
    vt[10] = '{5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, WB_ALU, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_NONE, 1'b0};
    vt[11] = '{5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, WB_MEM, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, FWD_NONE, FWD_NONE, 1'b0};
    vt[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, WB_ALU, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, FWD_NONE, FWD_NONE, 1'b0};
    vt[13] = '{5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, WB_PC4, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FWD_NONE, FWD_NONE, 1'b0};

    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("rst.stallF", hz.stallF, 1'b0);
    check("rst.flushE", hz.flushE, 1'b0);
    check("rst.fwdA", hz.forwardAE, FWD_NONE);
    check("rst.busy", hz.mdu_busy, 1'b0);
    check("rst.wb_valid", hz.mdu_wb_valid, 1'b0);
    check("rst.wb_rd", hz.mdu_wb_rd, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(vt[i]);
      exp_q.push_back(vt[i]);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d.stallF", i), hz.stallF, e.sF);
      check($sformatf("v%0d.stallD", i), hz.stallD, e.sD);
      check($sformatf("v%0d.flushD", i), hz.flushD, e.fD);
      check($sformatf("v%0d.flushE", i), hz.flushE, e.fE);
      check($sformatf("v%0d.fwdA", i), hz.forwardAE, e.aE);
      check($sformatf("v%0d.fwdB", i), hz.forwardBE, e.bE);
      check($sformatf("v%0d.fwdM", i), hz.forwardM, e.fM);
    end

    // RAW on an MDU result: stalls t..t+4, released at t+5.
    step(); hz.mdu_start_E = 1'b1; hz.rd_E = 5'd9; hz.rs1_D = 5'd9; mdu_q.push_back(5'd9);
    chk_mdu("raw.t0", 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= LAT; k++) begin
      step(); hz.rs1_D = 5'd9;
      chk_mdu($sformatf("raw.t%0d", k), 1'b1, 1'b1, k == LAT);
    end
    step(); hz.rs1_D = 5'd9;
    chk_mdu("raw.rel", 1'b0, 1'b0, 1'b0);

    // Structural and WAW stalls; independent instruction flows.
    step(); hz.mdu_start_E = 1'b1; hz.rd_E = 5'd9; hz.rs1_D = 5'd3; mdu_q.push_back(5'd9);
    chk_mdu("sw.issue", 1'b0, 1'b0, 1'b0);
    step(); hz.mdu_op_D = 1'b1;
    chk_mdu("sw.struct", 1'b1, 1'b1, 1'b0);
    step(); hz.reg_wr_D = 1'b1; hz.rd_D = 5'd9;
    chk_mdu("sw.waw", 1'b1, 1'b1, 1'b0);
    step(); hz.rs1_D = 5'd3; hz.reg_wr_D = 1'b1; hz.rd_D = 5'd4;
    chk_mdu("sw.indep", 1'b0, 1'b1, 1'b0);
    step(); hz.rs1_D = 5'd3;
    chk_mdu("sw.wb", 1'b0, 1'b1, 1'b1);
    step();
    chk_mdu("sw.idle", 1'b0, 1'b0, 1'b0);

    // Taken branch over a load-use stall while an MDU op is in flight.
    step(); hz.mdu_start_E = 1'b1; hz.rd_E = 5'd10; mdu_q.push_back(5'd10);
    chk_mdu("br.issue", 1'b0, 1'b0, 1'b0);
    step(); hz.sel_wb_E = WB_MEM; hz.rd_E = 5'd7; hz.rs2_D = 5'd7; hz.br_en_E = 1'b1;
    chk_mdu("br.t1", 1'b0, 1'b1, 1'b0);
    check("br.stallF", hz.stallF, 1'b0);
    check("br.flushD", hz.flushD, 1'b1);
    check("br.flushE", hz.flushE, 1'b1);
    step(); chk_mdu("br.t2", 1'b0, 1'b1, 1'b0);
    step(); chk_mdu("br.t3", 1'b0, 1'b1, 1'b0);
    step(); chk_mdu("br.t4", 1'b0, 1'b1, 1'b1);
    step(); chk_mdu("br.t5", 1'b0, 1'b0, 1'b0);

    // Reset while busy with cnt=2 aborts tracking.
    step(); hz.mdu_start_E = 1'b1; hz.rd_E = 5'd11; mdu_q.push_back(5'd11);
    chk_mdu("rb.issue", 1'b0, 1'b0, 1'b0);
    step(); chk_mdu("rb.t1", 1'b0, 1'b1, 1'b0);
    step(); chk_mdu("rb.t2", 1'b0, 1'b1, 1'b0);
    step(); hz.rs1_D = 5'd11;
    chk_mdu("rb.t3", 1'b1, 1'b1, 1'b0);
    #1 rst = 1'b1;
    mdu_q.delete();
    #1;
    check("rb.busy", hz.mdu_busy, 1'b0);
    check("rb.wb_rd", hz.mdu_wb_rd, 5'd0);
    check("rb.pend", hz.stallD, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("rb.stall_cnt", stall_cnt, 32'd0);
    check("rb.flush_cnt", flush_cnt, 32'd0);
    check("rb.mdu_stall_cnt", mdu_stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      step(); hz.rs1_D = 5'd11;
      chk_mdu($sformatf("rb.post%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // Mixed stall sources, also exercising the optional counters.
    for (int k = 0; k < 3; k++) begin
      step(); hz.sel_wb_E = WB_MEM; hz.rd_E = 5'd7; hz.rs1_D = 5'd7;
      chk_mdu($sformatf("pc.lu%0d", k), 1'b1, 1'b0, 1'b0);
    end
    step(); hz.mdu_start_E = 1'b1; hz.rd_E = 5'd12; mdu_q.push_back(5'd12);
    chk_mdu("pc.issue", 1'b0, 1'b0, 1'b0);
    step(); hz.rs1_D = 5'd12;
    chk_mdu("pc.raw", 1'b1, 1'b1, 1'b0);
    step(); hz.br_en_E = 1'b1;
    chk_mdu("pc.br", 1'b0, 1'b1, 1'b0);
    step(); chk_mdu("pc.t3", 1'b0, 1'b1, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("pc.stall_cnt", stall_cnt, 32'd4);
    check("pc.flush_cnt", flush_cnt, 32'd1);
    check("pc.mdu_stall_cnt", mdu_stall_cnt, 32'd1);
`endif
    step(); chk_mdu("pc.wb", 1'b0, 1'b1, 1'b1);
    step(); chk_mdu("pc.idle", 1'b0, 1'b0, 1'b0);

    check("mdu_q.empty", mdu_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
